jt900h_divctl: RTL

Sequencing front end for the jt900h_div unsigned divider. It accepts a DIV/DIVS request from the instruction sequencer and converts signed operands to magnitudes. It then launches the divider, waits for it to finish, and applies the sign and overflow rules. Finally it presents the packed {remainder, quotient} result with a one-cycle write-back strobe. The divider's own `sign` input is tied low; all sign handling lives here.

---
 rtl/jt900h_divctl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/jt900h_divctl.sv
// Sequencing front end for the jt900h_div unsigned divider: takes DIV/DIVS requests,
// feeds operand magnitudes to the divider and applies sign and overflow rules to its result.
module jt900h_divctl (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        req,
  input  logic        sign,
  input  logic        len,
  input  logic [31:0] dvd,
  input  logic [15:0] dvs,
  output logic        busy,
  output logic        done,
  output logic [31:0] res,
  output logic        v,
  output logic [31:0] div_op0,
  output logic [15:0] div_op1,
  output logic        div_len,
  output logic        div_start,
  input  logic [15:0] div_quot,
  input  logic [15:0] div_rem,
  input  logic        div_busy,
  input  logic        div_v
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q;
  logic        sign_q, len_q, sd_q, ss_q, zero_q, dv_q;
  logic [15:0] uq_q, ur_q;

  logic        sd_d, ss_d, dvs_zero_d;
  logic [31:0] op0_d;
  logic [15:0] op1_d;

  // Operand signs and magnitudes of the incoming request
  always_comb begin
    sd_d       = sign & (len ? dvd[31] : dvd[15]);
    ss_d       = sign & (len ? dvs[15] : dvs[7]);
    dvs_zero_d = len ? (dvs == 16'h0000) : (dvs[7:0] == 8'h00);
    if (len) begin
      op0_d = sd_d ? 32'(-dvd) : dvd;
      op1_d = ss_d ? 16'(-dvs) : dvs;
    end else begin
      op0_d = {16'h0000, (sd_d ? 16'(-dvd[15:0]) : dvd[15:0])};
      op1_d = {8'h00, (ss_d ? 8'(-dvs[7:0]) : dvs[7:0])};
    end
  end

  logic        nq_d, range_ov_d, v_fix_d;
  logic [15:0] q16_d, r16_d, lim_d;
  logic [7:0]  q8_d, r8_d;
  logic [31:0] res_fix_d;

  // Signed fix-up of the divider result; the remainder takes the dividend's sign
  always_comb begin
    nq_d       = sd_q ^ ss_q;
    q16_d      = nq_d ? 16'(-uq_q) : uq_q;
    r16_d      = sd_q ? 16'(-ur_q) : ur_q;
    q8_d       = nq_d ? 8'(-uq_q[7:0]) : uq_q[7:0];
    r8_d       = sd_q ? 8'(-ur_q[7:0]) : ur_q[7:0];
    lim_d      = len_q ? (nq_d ? 16'h8000 : 16'h7FFF) : (nq_d ? 16'h0080 : 16'h007F);
    range_ov_d = sign_q & (uq_q > lim_d);
    v_fix_d    = zero_q | dv_q | range_ov_d;
    res_fix_d  = len_q ? {r16_d, q16_d} : {16'h0000, r8_d, q8_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      v         <= 1'b0;
      res       <= 32'h0;
      div_op0   <= 32'h0;
      div_op1   <= 16'h0;
      div_len   <= 1'b0;
      div_start <= 1'b0;
      sign_q    <= 1'b0;
      len_q     <= 1'b0;
      sd_q      <= 1'b0;
      ss_q      <= 1'b0;
      zero_q    <= 1'b0;
      dv_q      <= 1'b0;
      uq_q      <= 16'h0;
      ur_q      <= 16'h0;
    end else if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            sign_q  <= sign;
            len_q   <= len;
            sd_q    <= sd_d;
            ss_q    <= ss_d;
            div_op0 <= op0_d;
            div_op1 <= op1_d;
            div_len <= len;
            busy    <= 1'b1;
            dv_q    <= 1'b0;
            zero_q  <= dvs_zero_d;
            // A zero divisor never reaches the divider
            if (dvs_zero_d) begin
              state_q <= S_FIX;
            end else begin
              div_start <= 1'b1;
              state_q   <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (div_busy) begin
            div_start <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!div_busy) begin
            uq_q    <= div_quot;
            ur_q    <= div_rem;
            dv_q    <= div_v;
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          v    <= v_fix_d;
          if (!v_fix_d) res <= res_fix_d;
          done    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          div_start <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
